noise_rr_scheduler: RTL and testbench
=====================================

Name: noise_rr_scheduler

Overview:
Round-robin scheduler that shares one LFSR noise generator among N_REQ requesters (e.g. per-channel noise injectors).
- Grants the generator to one requester at a time for a burst of up to BURST_LEN consecutive samples.
- Drives the generator's enable and noise_level inputs with the granted requester's level.
- Returns each captured sample, tagged with the requester id.
- Sits between the requesters and the noise generator instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester id; must equal ceil(log2(N_REQ))
BURST_LEN, 4, samples per grant (1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request; level-held for the duration of the burst
req_level  in  2*N_REQ  noise level of requester i on bits [2i+1:2i]; 00 none, 01 low, 10 mid, 11 high
grant  out  N_REQ  one-hot, registered; current owner of the generator
gen_enable  out  1  to generator enable
gen_level  out  2  to generator noise_level
gen_noise  in  16  generator output (combinational from its state and inputs)
rsp_valid  out  1  registered, one-cycle pulse per sample
rsp_id  out  ID_W  owner index for this sample
rsp_data  out  16  captured sample
rsp_last  out  1  with rsp_valid, marks the final sample of a completed burst
busy  out  1  high while in SERVE

Behaviour:
- Reset: async, immediate.
  - state=IDLE, ptr=0, grant=0, owner=0, lvl_q=00, cnt=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_last=0, busy=0.
  - gen_enable=0, gen_level=00.
  - Reset mid-burst aborts the burst with no further responses.
- States: IDLE, SERVE.
- IDLE:
  - If req==0, stay in IDLE.
  - Else pick winner = first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - At the clock edge: owner<=winner, lvl_q<=req_level[winner], grant<=onehot(winner), cnt<=0, state<=SERVE.
- SERVE, when req[owner]=1:
  - gen_enable=1 and gen_level=lvl_q (combinational from registers).
  - At the edge: rsp_valid<=1, rsp_data<=gen_noise, rsp_id<=owner, rsp_last<=(cnt==BURST_LEN-1).
  - If cnt==BURST_LEN-1: state<=IDLE, grant<=0, ptr<=(owner+1) mod N_REQ. Otherwise cnt<=cnt+1.
- SERVE, when req[owner]=0 (abort):
  - gen_enable=0, no sample, rsp_valid<=0.
  - state<=IDLE, grant<=0, ptr<=(owner+1) mod N_REQ.
  - No rsp_last is issued for an aborted burst.
- Outside SERVE: gen_enable=0, gen_level=00, busy=0. rsp_valid/rsp_last default to 0 on every edge without a sample.
- lvl_q is latched at grant only; req_level changes mid-burst are ignored.
- A level of 00 is still granted and served; rsp_data=0, as produced by the generator.
- Timing:
  - Request seen at edge E gives grant high after E.
  - Samples are captured at edges E+1..E+BURST_LEN; rsp_valid is high in the cycles after those edges.
  - One mandatory IDLE cycle follows each burst; the next grant is earliest after edge E+BURST_LEN+1.
- Fairness: a requester that holds req continuously is served within (N_REQ-1) bursts plus idle cycles.
- ptr updates only at burst end or abort. Requests arriving mid-burst wait; there is no preemption.
- ID_W≠ceil(log2(N_REQ)) is a configuration error (elaboration assertion).

Test Plan:
- Single requester: req=0001, level[1:0]=10, bench drives gen_noise=0x0100+cycle → grant=0001 for 4 cycles; gen_enable=1 and gen_level=10 for 4 cycles; 4 rsp_valid pulses with rsp_id=0 and rsp_data matching gen_noise at each capture edge; rsp_last only on the 4th; busy low for one cycle afterwards.
- All requesting: req=1111 held → bursts in order id 0,1,2,3,0; each 4 samples; exactly one IDLE cycle between bursts.
- Round-robin wrap: ptr=3 after serving id 2, req=0101 → next grant id 0, then id 2.
- Abort: req[1] dropped after 2 samples → exactly 2 responses, no rsp_last, grant clears next edge, ptr=2.
- Level latch: req_level[3:2] changes 01→11 mid-burst → gen_level stays 01 for the entire burst; a 00-level request yields 4 responses of 0x0000.
- Reset in SERVE after 1 sample → grant, rsp_valid, gen_enable and busy go 0 immediately; after release with req=0010, the grant goes to id 1 (ptr=0 search).

Source files
------------

// File: rtl/noise_rr_scheduler.sv
// noise_rr_scheduler: round-robin sharing of one noise generator; grants bursts of BURST_LEN samples, returns tagged samples
module noise_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_level,
  output logic [N_REQ-1:0]   grant,
  output logic               gen_enable,
  output logic [1:0]         gen_level,
  input  logic [15:0]        gen_noise,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_data,
  output logic               rsp_last,
  output logic               busy
);
  if (ID_W != $clog2(N_REQ)) begin : g_cfg
    $error("ID_W must equal clog2(N_REQ)");
  end
  typedef enum logic {IDLE, SERVE} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] ptr, owner, winner, idx, nxt_ptr;
  logic [1:0] lvl_q;
  logic [7:0] cnt;
  logic last;
  assign last = cnt == 8'(BURST_LEN - 1);
  assign nxt_ptr = owner == ID_W'(N_REQ - 1) ? '0 : owner + 1'b1;
  assign busy = state == SERVE;
  assign gen_enable = busy && req[owner];
  assign gen_level = gen_enable ? lvl_q : 2'b00;
  always_comb begin
    winner = ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      winner = req[idx] ? idx : winner;
    end
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = |req ? SERVE : IDLE;
    else if (!req[owner] || last) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      lvl_q <= 2'b00;
      cnt <= '0;
      grant <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
    end else begin
      state <= state_n;
      rsp_valid <= 1'b0;
      rsp_last <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          owner <= winner;
          lvl_q <= req_level[{winner, 1'b0} +: 2];
          grant <= N_REQ'(1) << winner;
          cnt <= '0;
        end
      end else begin
        if (req[owner]) begin
          rsp_valid <= 1'b1;
          rsp_data <= gen_noise;
          rsp_id <= owner;
          rsp_last <= last;
          cnt <= cnt + 8'd1;
        end
        if (!req[owner] || last) begin
          grant <= '0;
          ptr <= nxt_ptr;
        end
      end
    end
  end
endmodule

// File: tb/tb_noise_rr_scheduler.sv
// tb_noise_rr_scheduler: scoreboard bench with behavioural reference model for noise_rr_scheduler
module tb_noise_rr_scheduler;
  localparam int N = 4;
  localparam int B = 4;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] req = '0;
  logic [7:0] req_level = '0;
  logic [15:0] gen_noise = '0;
  logic [3:0] grant;
  logic gen_enable, rsp_valid, rsp_last, busy;
  logic [1:0] gen_level, rsp_id;
  logic [15:0] rsp_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [18:0] exp_q[$];
  logic [18:0] e;
  bit m_srv = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_left = 0;
  logic [1:0] m_lvl = '0;
  noise_rr_scheduler #(.N_REQ(N), .ID_W(2), .BURST_LEN(B)) dut (
    .clk(clk), .reset(reset), .req(req), .req_level(req_level), .grant(grant),
    .gen_enable(gen_enable), .gen_level(gen_level), .gen_noise(gen_noise),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got id %0d data %h last %b (cycle %0d)", rsp_id, rsp_data, rsp_last, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {13'd0, rsp_id, rsp_data, rsp_last}, {13'd0, e});
      end
    end else begin
      chk("idle_last", {31'd0, rsp_last}, 32'd0);
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp got none expected %h (cycle %0d)", exp_q[0], cyc);
        exp_q.delete();
      end
    end
  end
  task automatic step(input logic [3:0] r, input logic [7:0] lv, input logic [15:0] nz);
    bit en;
    int w;
    @(negedge clk);
    req = r;
    req_level = lv;
    gen_noise = nz;
    cyc++;
    #1;
    en = m_srv && r[m_owner];
    chk("busy", {31'd0, busy}, {31'd0, m_srv});
    chk("grant", {28'd0, grant}, m_srv ? 32'd1 << m_owner : 32'd0);
    chk("gen_enable", {31'd0, gen_enable}, {31'd0, en});
    chk("gen_level", {30'd0, gen_level}, en ? {30'd0, m_lvl} : 32'd0);
    if (!m_srv) begin
      if (r != 0) begin
        w = -1;
        for (int j = 0; j < N; j++) if (w < 0 && r[(m_ptr + j) % N]) w = (m_ptr + j) % N;
        m_owner = w;
        m_lvl = lv[2*w +: 2];
        m_left = B;
        m_srv = 1;
      end
    end else if (r[m_owner]) begin
      exp_q.push_back({2'(m_owner), nz, m_left == 1});
      m_left--;
      if (m_left == 0) begin
        m_srv = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end else begin
      m_srv = 0;
      m_ptr = (m_owner + 1) % N;
    end
  endtask
  task automatic reset_mid();
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_gen_enable", {31'd0, gen_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    m_srv = 0;
    m_ptr = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    req = '0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("init_grant", {28'd0, grant}, 32'd0);
    chk("init_rsp", {13'd0, rsp_id, rsp_data, rsp_last}, 32'd0);
    chk("init_gen", {29'd0, gen_enable, gen_level}, 32'd0);
    reset = 0;
    for (int i = 0; i < 5; i++) step(4'b0001, 8'b10, 16'(32'h0100 + cyc + 1));
    for (int i = 0; i < 2; i++) step(4'b0000, 8'b10, 16'(32'h0100 + cyc + 1));
    reset_mid();
    for (int i = 0; i < 25; i++) step(4'b1111, 8'($urandom), 16'($urandom));
    reset_mid();
    for (int i = 0; i < 5; i++) step(4'b0100, 8'($urandom), 16'($urandom));
    for (int i = 0; i < 12; i++) step(4'b0101, 8'($urandom), 16'($urandom));
    reset_mid();
    for (int i = 0; i < 3; i++) step(4'b0010, 8'($urandom), 16'($urandom));
    for (int i = 0; i < 2; i++) step(4'b0000, 8'($urandom), 16'($urandom));
    for (int i = 0; i < 6; i++) step(4'b1111, 8'($urandom), 16'($urandom));
    reset_mid();
    for (int i = 0; i < 2; i++) step(4'b0010, 8'b0000_0100, 16'($urandom));
    for (int i = 0; i < 4; i++) step(4'b0010, 8'b0000_1100, 16'($urandom));
    step(4'b0000, 8'h00, 16'h0000);
    for (int i = 0; i < 5; i++) step(4'b1000, 8'h00, 16'h0000);
    step(4'b0000, 8'h00, 16'h0000);
    reset_mid();
    for (int i = 0; i < 2; i++) step(4'b0010, 8'($urandom), 16'($urandom));
    reset_mid();
    for (int i = 0; i < 6; i++) step(4'b0010, 8'($urandom), 16'($urandom));
    begin
      logic [3:0] r = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
        step(r, 8'($urandom), 16'($urandom));
      end
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 8'h00, 16'h0000);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
